serial_queue_param: RTL and testbench



---
 rtl/serial_queue_pkg.sv | 14 +
 rtl/sq_fifo.sv | 61 ++++++
 rtl/serial_queue_param.sv | 98 +++++++++
 tb/tb_serial_queue_param.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_queue_pkg.sv
// serial_queue_pkg: shared FSM state type, default parameters and pointer-width helper
package serial_queue_pkg;

    typedef enum logic {IDLE, SHIFT} sq_state_t;

    localparam int SQ_WIDTH_DEF = 8;
    localparam int SQ_DEPTH_DEF = 8;
    localparam int SQ_DIV_DEF   = 100;

    function automatic int clog2_plus1(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/sq_fifo.sv
// sq_fifo: synchronous FIFO with registered read data, level and full/empty/drop flags
// SERIAL_QUEUE_OVERWRITE_EN makes a push while full replace the oldest entry
module sq_fifo
    import serial_queue_pkg::*;
#(
    parameter int WIDTH = SQ_WIDTH_DEF,
    parameter int DEPTH = SQ_DEPTH_DEF
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            push_i,
    input  logic                            pop_i,
    input  logic [WIDTH-1:0]                wdata_i,
    output logic [WIDTH-1:0]                rdata_o,
    output logic [clog2_plus1(DEPTH)-1:0]   level_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic                            drop_o
);
    localparam int PW = clog2_plus1(DEPTH);
    localparam int AW = PW - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             do_push, do_pop;

    assign level_o = wr_q - rd_q;
    assign full_o  = level_o == PW'(DEPTH);
    assign empty_o = level_o == '0;
    assign do_pop  = pop_i && !empty_o;
    // a simultaneous pop frees a slot, so only an unpaired push into a full FIFO overflows
    assign drop_o  = push_i && full_o && !do_pop;
`ifdef SERIAL_QUEUE_OVERWRITE_EN
    assign do_push = push_i;
    assign rd_d    = rd_q + PW'(do_pop || drop_o);
`else
    assign do_push = push_i && !drop_o;
    assign rd_d    = rd_q + PW'(do_pop);
`endif
    assign wr_d    = wr_q + PW'(do_push);
    assign rdata_d = do_pop ? mem_q[rd_q[AW-1:0]] : rdata_q;
    assign rdata_o = rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/serial_queue_param.sv
// serial_queue_param: mid-bit sampling deserialiser feeding a DEPTH-word FIFO
// SERIAL_QUEUE_OVERWRITE_EN (in sq_fifo) selects overwrite-oldest instead of drop on overflow
module serial_queue_param
    import serial_queue_pkg::*;
#(
    parameter int WIDTH = SQ_WIDTH_DEF,
    parameter int DEPTH = SQ_DEPTH_DEF,
    parameter int DIV   = SQ_DIV_DEF
) (
    input  logic                            clock1M,
    input  logic                            reset,
    input  logic                            data_in,
    input  logic                            write_in,
    input  logic                            dequeue_in,
    output logic [WIDTH-1:0]                data_out,
    output logic                            status_out,
    output logic                            empty_out,
    output logic [clog2_plus1(DEPTH)-1:0]   level_out,
    output logic                            overflow_out
);
    localparam int DW = $clog2(DIV);
    localparam int CW = $clog2(WIDTH);

    sq_state_t        state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             push_q, push_d;
    logic             write_q, deq_q, pop_q, ovf_q, drop;
    logic             mid, last;

    assign mid  = div_q == DW'(DIV / 2 - 1);
    assign last = cnt_q == CW'(WIDTH - 1);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        push_d  = 1'b0;
        if (state_q == IDLE) begin
            if (write_in && !write_q) begin
                state_d = SHIFT;
                div_d   = '0;
                cnt_d   = '0;
            end
        end else if (!write_in) begin
            state_d = IDLE;
        end else begin
            div_d = (div_q == DW'(DIV - 1)) ? '0 : div_q + DW'(1);
            if (mid) begin
                sh_d   = {sh_q[WIDTH-2:0], data_in};
                cnt_d  = last ? '0 : cnt_q + CW'(1);
                push_d = last;
            end
        end
    end

    always_ff @(posedge clock1M) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            push_q  <= 1'b0;
            write_q <= 1'b0;
            deq_q   <= 1'b0;
            pop_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            push_q  <= push_d;
            write_q <= write_in;
            deq_q   <= dequeue_in;
            pop_q   <= dequeue_in && !deq_q;
            ovf_q   <= ovf_q || drop;
        end
    end

    sq_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clock1M),
        .rst_i   (reset),
        .push_i  (push_q),
        .pop_i   (pop_q),
        .wdata_i (sh_q),
        .rdata_o (data_out),
        .level_o (level_out),
        .full_o  (status_out),
        .empty_o (empty_out),
        .drop_o  (drop)
    );

    assign overflow_out = ovf_q;

endmodule

// File: tb/tb_serial_queue_param.sv
// tb_serial_queue_param: directed and randomized frames checked against a queue-based reference model
module tb_serial_queue_param;
    localparam int W  = 8;
    localparam int D  = 8;
    localparam int DV = 100;

    logic clk = 1'b0, rst = 1'b1, din = 1'b0, wr = 1'b0, deq = 1'b0;
    logic [W-1:0] dout;
    logic [3:0]   lvl;
    logic         full, empty, ovf;
    int tests = 0, fails = 0;

    logic [W-1:0] mq[$];
    logic [W-1:0] m_dout = '0;
    logic         m_ovf  = 1'b0;

    always #5 clk = ~clk;

    serial_queue_param #(.WIDTH(W), .DEPTH(D), .DIV(DV)) dut (
        .clock1M(clk), .reset(rst), .data_in(din), .write_in(wr), .dequeue_in(deq),
        .data_out(dout), .status_out(full), .empty_out(empty), .level_out(lvl), .overflow_out(ovf)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_push(input logic [W-1:0] w);
        if (mq.size() < D) mq.push_back(w);
        else begin
            m_ovf = 1'b1;
`ifdef SERIAL_QUEUE_OVERWRITE_EN
            mq.delete(0);
            mq.push_back(w);
`endif
        end
    endtask

    task automatic m_pop();
        if (mq.size() > 0) m_dout = mq.pop_front();
    endtask

    task automatic m_reset();
        mq.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr = 1'b0; deq = 1'b0; din = 1'b0;
        tick(3);
        rst = 1'b0;
        m_reset();
        tick(2);
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        wr = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            din = v[i];
            tick(DV);
        end
        wr = 1'b0;
        din = 1'b0;
        tick(5);
    endtask

    task automatic frame_words(input logic [63:0] v, input int nw, input int extra);
        send_bits(v, nw * W + extra);
        for (int k = 0; k < nw; k++) m_push(v[(nw - 1 - k) * W + extra +: W]);
    endtask

    task automatic pulse_deq();
        deq = 1'b1;
        tick(1);
        deq = 1'b0;
        tick(3);
        m_pop();
    endtask

    task automatic test_reset();
        tick(100);
        tests++;
        if ({dout, lvl, full, empty, ovf} !== {8'h00, 4'd0, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset: dout=%h lvl=%0d full=%b empty=%b ovf=%b, want 00/0/0/1/0", dout, lvl, full, empty, ovf);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        fork
            send_bits(64'hAA, 8);
            begin
                tick(745);
                tests++;
                if (lvl !== 4'd0) begin fails++; $display("FAIL basic_early: lvl=%0d want 0", lvl); end
                tick(15);
                tests++;
                if (lvl !== 4'd1 || empty !== 1'b0) begin fails++; $display("FAIL basic_push: lvl=%0d empty=%b want 1/0", lvl, empty); end
            end
        join
        m_push(8'hAA);
        pulse_deq();
        tests++;
        if ({dout, lvl, empty} !== {m_dout, 4'(mq.size()), 1'b1}) begin
            fails++;
            $display("FAIL basic_pop: dout=%h lvl=%0d empty=%b want %h/0/1", dout, lvl, empty, m_dout);
        end
    endtask

    task automatic test_back_to_back();
        send_bits(64'hCCF00F335599FF00, 64);
        for (int k = 7; k >= 0; k--) m_push(8'(64'hCCF00F335599FF00 >> (k * 8)));
        tests++;
        if ({lvl, full, empty} !== {4'(mq.size()), 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL b2b_full: lvl=%0d full=%b empty=%b want %0d/1/0", lvl, full, empty, mq.size());
        end
    endtask

    task automatic test_overflow();
        frame_words(64'h5A, 1, 0);
        tests++;
        if ({lvl, full, ovf} !== {4'd8, 1'b1, m_ovf}) begin
            fails++;
            $display("FAIL ovf_flags: lvl=%0d full=%b ovf=%b want 8/1/%b", lvl, full, ovf, m_ovf);
        end
        for (int k = 0; k < D; k++) begin
            pulse_deq();
            tests++;
            if (dout !== m_dout) begin fails++; $display("FAIL ovf_drain[%0d]: dout=%h want %h", k, dout, m_dout); end
        end
        tests++;
        if ({empty, lvl, ovf} !== {1'b1, 4'd0, 1'b1}) begin
            fails++;
            $display("FAIL ovf_empty: empty=%b lvl=%0d ovf=%b want 1/0/1", empty, lvl, ovf);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w;
        w = W'($urandom) | 8'h01;
        frame_words({40'd0, w, 16'h3C7E}, 3, 0);
        pulse_deq();
        wr = 1'b1;
        din = 1'b1;
        tick(450);
        rst = 1'b1;
        tick(1);
        m_reset();
        tests++;
        if ({dout, lvl, empty, ovf, full} !== {m_dout, 4'd0, 1'b1, m_ovf, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid: dout=%h lvl=%0d empty=%b ovf=%b full=%b want 00/0/1/0/0", dout, lvl, empty, ovf, full);
        end
        rst = 1'b0; wr = 1'b0; din = 1'b0;
        tick(5);
        pulse_deq();
        tests++;
        if (dout !== m_dout || empty !== 1'b1) begin fails++; $display("FAIL reset_stale: dout=%h empty=%b want %h/1", dout, empty, m_dout); end
    endtask

    task automatic test_partial();
        send_bits(64'h1B, 5);
        tests++;
        if (lvl !== 4'(mq.size())) begin fails++; $display("FAIL partial_level: lvl=%0d want %0d", lvl, mq.size()); end
        frame_words(64'h81, 1, 0);
        pulse_deq();
        tests++;
        if (dout !== 8'h81 || dout !== m_dout || lvl !== 4'(mq.size())) begin
            fails++;
            $display("FAIL partial_next: dout=%h lvl=%0d want 81/%0d", dout, lvl, mq.size());
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] w;
        logic bad;
        do_reset();
        frame_words(64'h112233, 3, 0);
        w = W'($urandom);
        bad = 1'b0;
        fork
            send_bits({56'd0, w}, 8);
            begin
                tick(750);
                deq = 1'b1;
                tick(1);
                deq = 1'b0;
            end
            begin
                tick(740);
                repeat (30) begin
                    if (lvl !== 4'd3) bad = 1'b1;
                    tick(1);
                end
            end
        join
        m_pop();
        m_push(w);
        tests++;
        if (bad || lvl !== 4'(mq.size()) || dout !== m_dout) begin
            fails++;
            $display("FAIL simul: level_moved=%b lvl=%0d dout=%h want 3/%h", bad, lvl, dout, m_dout);
        end
        while (mq.size() > 0) begin
            pulse_deq();
            tests++;
            if (dout !== m_dout) begin fails++; $display("FAIL simul_drain: dout=%h want %h", dout, m_dout); end
        end
        pulse_deq();
        tests++;
        if (dout !== m_dout || empty !== 1'b1) begin fails++; $display("FAIL pop_empty: dout=%h empty=%b want %h/1", dout, empty, m_dout); end
    endtask

    task automatic test_random();
        logic [63:0] v;
        int nw, extra, np;
        do_reset();
        for (int it = 0; it < 6; it++) begin
            nw = $urandom_range(1, 3);
            extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            v = {$urandom, $urandom};
            frame_words(v, nw, extra);
            tests++;
            if ({lvl, full, empty, ovf} !== {4'(mq.size()), mq.size() == D, mq.size() == 0, m_ovf}) begin
                fails++;
                $display("FAIL rand_flags[%0d]: lvl=%0d full=%b empty=%b ovf=%b want lvl=%0d ovf=%b", it, lvl, full, empty, ovf, mq.size(), m_ovf);
            end
            np = $urandom_range(0, 3);
            for (int p = 0; p < np; p++) begin
                pulse_deq();
                tests++;
                if (dout !== m_dout || lvl !== 4'(mq.size())) begin
                    fails++;
                    $display("FAIL rand_pop[%0d]: dout=%h lvl=%0d want %h/%0d", it, dout, lvl, m_dout, mq.size());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_partial();
        test_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
